// File: rtl/guess_injector_if.sv
// Request/response and pushbutton bundle between a guess requester and the guess injector.
// The injector takes the slave view; the requester (demo logic or bench) takes the master view.
interface guess_injector_if;
    logic       start;
    logic [1:0] max_digits;
    logic [3:0] cur_digit_1;
    logic [3:0] cur_digit_2;
    logic [3:0] cur_digit_3;
    logic [3:0] guess_digit_1;
    logic [3:0] guess_digit_2;
    logic [3:0] guess_digit_3;
    logic [2:0] digit_btn_n;
    logic       confirm_btn_n;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, max_digits,
        output cur_digit_1, cur_digit_2, cur_digit_3,
        output guess_digit_1, guess_digit_2, guess_digit_3,
        input  digit_btn_n, confirm_btn_n, busy, done, err
    );

    modport slave (
        input  start, max_digits,
        input  cur_digit_1, cur_digit_2, cur_digit_3,
        input  guess_digit_1, guess_digit_2, guess_digit_3,
        output digit_btn_n, confirm_btn_n, busy, done, err
    );
endinterface

// File: rtl/guess_injector.sv
// Enters a full guess on the active-low pushbutton interface: timed presses on each digit
// button to walk it from the displayed value to the guess, then one confirm press.
module guess_injector #(
    parameter int PRESS_CYCLES   = 16,
    parameter int RELEASE_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    guess_injector_if.slave  bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_SELECT   = 3'd2;
    localparam logic [2:0] S_PRESS    = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;
    localparam logic [2:0] S_CPRESS   = 3'd5;
    localparam logic [2:0] S_CRELEASE = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [2:0]       NONE   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       n_q [3];
    logic [3:0]       n_d [3];
    logic [1:0]       max_q;
    logic [3:0]       cur_q [3];
    logic [3:0]       guess_q [3];
    logic [2:0]       digBtn_q, digBtn_d;
    logic             confBtn_q, confBtn_d;
    logic             err_q, err_d;
    logic             accept;
    logic             take;
    logic [2:0]       nxt;

    function automatic logic [3:0] modDiff(input logic [3:0] g, input logic [3:0] c);
        logic [4:0] d;
        if (g >= c) d = {1'b0, g} - {1'b0, c};
        else        d = {1'b0, g} + 5'd10 - {1'b0, c};
        return d[3:0];
    endfunction

    // Lowest active digit at or after 'from' that still needs presses, or NONE.
    function automatic logic [2:0] nextDigit(input logic [2:0] from, input logic [1:0] maxd,
                                             input logic [3:0] n0, input logic [3:0] n1,
                                             input logic [3:0] n2);
        logic [2:0] r;
        r = NONE;
        if (from <= 3'd3 && maxd >= 2'd3 && n2 != 4'd0) r = 3'd3;
        if (from <= 3'd2 && maxd >= 2'd2 && n1 != 4'd0) r = 3'd2;
        if (from <= 3'd1 && maxd >= 2'd1 && n0 != 4'd0) r = 3'd1;
        return r;
    endfunction

    assign accept = (bus.max_digits != 2'd0)
                  && (bus.guess_digit_1 <= 4'd9) && (bus.cur_digit_1 <= 4'd9)
                  && (bus.max_digits < 2'd2 || (bus.guess_digit_2 <= 4'd9 && bus.cur_digit_2 <= 4'd9))
                  && (bus.max_digits < 2'd3 || (bus.guess_digit_3 <= 4'd9 && bus.cur_digit_3 <= 4'd9));
    assign take   = (state_q == S_IDLE) && bus.start && accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        nxt     = NONE;
        for (int i = 0; i < 3; i++) n_d[i] = n_q[i];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (accept) state_d = S_LOAD;
                    else        err_d   = 1'b1;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < 3; i++) n_d[i] = modDiff(guess_q[i], cur_q[i]);
                idx_d   = 3'd1;
                state_d = S_SELECT;
            end
            // Zero-count digits are skipped within this one cycle; a second visit ends the digits.
            S_SELECT: begin
                if (idx_q > {1'b0, max_q}) begin
                    state_d = S_CPRESS;
                    cnt_d   = P_LOAD;
                end else begin
                    nxt = nextDigit(idx_q, max_q, n_q[0], n_q[1], n_q[2]);
                    if (nxt != NONE) begin
                        idx_d   = nxt;
                        state_d = S_PRESS;
                        cnt_d   = P_LOAD;
                    end else begin
                        idx_d = NONE;
                    end
                end
            end
            S_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RELEASE;
                    cnt_d   = R_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == '0) begin
                    for (int i = 0; i < 3; i++)
                        if (idx_q == 3'(i + 1)) n_d[i] = n_q[i] - 4'd1;
                    if ((idx_q == 3'd1 && n_q[0] == 4'd1) || (idx_q == 3'd2 && n_q[1] == 4'd1) ||
                        (idx_q == 3'd3 && n_q[2] == 4'd1)) begin
                        nxt = nextDigit(idx_q + 3'd1, max_q, n_q[0], n_q[1], n_q[2]);
                        if (nxt != NONE) begin
                            idx_d   = nxt;
                            state_d = S_PRESS;
                            cnt_d   = P_LOAD;
                        end else begin
                            idx_d   = NONE;
                            state_d = S_SELECT;
                        end
                    end else begin
                        state_d = S_PRESS;
                        cnt_d   = P_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CPRESS: begin
                if (cnt_q == '0) begin
                    state_d = S_CRELEASE;
                    cnt_d   = R_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CRELEASE: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Button levels are derived from the next state so the pins are pure flop outputs.
    always_comb begin
        digBtn_d  = 3'b111;
        confBtn_d = (state_d != S_CPRESS);
        if (state_d == S_PRESS) begin
            for (int i = 0; i < 3; i++)
                if (idx_d == 3'(i + 1)) digBtn_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            max_q     <= '0;
            digBtn_q  <= 3'b111;
            confBtn_q <= 1'b1;
            err_q     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                n_q[i]     <= '0;
                cur_q[i]   <= '0;
                guess_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            digBtn_q  <= digBtn_d;
            confBtn_q <= confBtn_d;
            err_q     <= err_d;
            for (int i = 0; i < 3; i++) n_q[i] <= n_d[i];
            if (take) begin
                max_q      <= bus.max_digits;
                cur_q[0]   <= bus.cur_digit_1;
                cur_q[1]   <= bus.cur_digit_2;
                cur_q[2]   <= bus.cur_digit_3;
                guess_q[0] <= bus.guess_digit_1;
                guess_q[1] <= bus.guess_digit_2;
                guess_q[2] <= bus.guess_digit_3;
            end
        end
    end

    assign bus.digit_btn_n   = digBtn_q;
    assign bus.confirm_btn_n = confBtn_q;
    assign bus.busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.err           = err_q;

endmodule

// File: tb/tb_guess_injector.sv
// Directed bench for guess_injector: a scoreboard of expected press counts is filled when a
// start is driven and drained when the injector reports done (or err).
module tb_guess_injector;

    localparam int P = 4;
    localparam int R = 4;

    typedef struct {
        int n0;
        int n1;
        int n2;
        bit isErr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    guess_injector_if bus ();

    guess_injector #(.PRESS_CYCLES(P), .RELEASE_CYCLES(R), .CNT_W(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pins();
        return int'({bus.confirm_btn_n, bus.digit_btn_n});
    endfunction

    // Drive one start request and record what the injector should do with it.
    task automatic applyStimulus(input int m, input int c1, input int c2, input int c3,
                                 input int g1, input int g2, input int g3);
        exp_t e;
        int   c[3];
        int   g[3];
        int   n[3];
        c = '{c1, c2, c3};
        g = '{g1, g2, g3};
        e.isErr = (m == 0);
        for (int i = 0; i < 3; i++) begin
            n[i] = 0;
            if (i < m) begin
                if (g[i] > 9 || c[i] > 9) e.isErr = 1'b1;
                n[i] = (g[i] - c[i] + 10) % 10;
            end
        end
        e.n0 = n[0];
        e.n1 = n[1];
        e.n2 = n[2];
        sb.push_back(e);
        @(negedge clk);
        bus.max_digits    = 2'(m);
        bus.cur_digit_1   = 4'(c1);
        bus.cur_digit_2   = 4'(c2);
        bus.cur_digit_3   = 4'(c3);
        bus.guess_digit_1 = 4'(g1);
        bus.guess_digit_2 = 4'(g2);
        bus.guess_digit_3 = 4'(g3);
        bus.start         = 1'b1;
    endtask

    task automatic expectAccepted(input string tag, input int disturbAt, input bit startInDone);
        exp_t e;
        int   presses[4];
        int   lowRun[4];
        int   badWidth, overlap, busyCyc, errCyc, doneSeen, sum;
        logic [3:0] cur, prev;
        e = sb.pop_front();
        presses  = '{0, 0, 0, 0};
        lowRun   = '{0, 0, 0, 0};
        badWidth = 0; overlap = 0; busyCyc = 0; errCyc = 0; doneSeen = 0;
        prev     = 4'hF;
        for (int cyc = 0; cyc < 3000 && doneSeen == 0; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == disturbAt) begin
                bus.start         = 1'b1;
                bus.cur_digit_1   = 4'd0;
                bus.cur_digit_2   = 4'd0;
                bus.cur_digit_3   = 4'd0;
                bus.guess_digit_1 = 4'd9;
                bus.guess_digit_2 = 4'd9;
                bus.guess_digit_3 = 4'd9;
            end
            cur = 4'(pins());
            for (int i = 0; i < 4; i++) begin
                if (!cur[i]) begin
                    if (prev[i]) presses[i]++;
                    lowRun[i]++;
                end else begin
                    if (!prev[i] && lowRun[i] != P) badWidth++;
                    lowRun[i] = 0;
                end
            end
            prev = cur;
            if ($countones(~cur) > 1) overlap++;
            if (bus.busy) busyCyc++;
            if (bus.err) errCyc++;
            if (bus.done) begin
                doneSeen = 1;
                if (startInDone) begin
                    bus.start         = 1'b1;
                    bus.max_digits    = 2'd1;
                    bus.cur_digit_1   = 4'd0;
                    bus.guess_digit_1 = 4'd1;
                end
            end
        end
        sum = e.n0 + e.n1 + e.n2;
        checkOutput({tag, ".done"},      doneSeen, 1);
        checkOutput({tag, ".press1"},    presses[0], e.n0);
        checkOutput({tag, ".press2"},    presses[1], e.n1);
        checkOutput({tag, ".press3"},    presses[2], e.n2);
        checkOutput({tag, ".confirm"},   presses[3], 1);
        checkOutput({tag, ".busyCyc"},   busyCyc, 3 + sum * (P + R) + (P + R));
        checkOutput({tag, ".width"},     badWidth, 0);
        checkOutput({tag, ".overlap"},   overlap, 0);
        checkOutput({tag, ".errCyc"},    errCyc, 0);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput({tag, ".donePulse"}, int'(bus.done), 0);
        checkOutput({tag, ".idleBusy"},  int'(bus.busy), 0);
        @(negedge clk);
        checkOutput({tag, ".stayIdle"},  int'(bus.busy), 0);
        checkOutput({tag, ".idlePins"},  pins(), 15);
    endtask

    task automatic expectRejected(input string tag);
        exp_t e;
        e = sb.pop_front();
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput({tag, ".errFlag"}, int'(bus.err), int'(e.isErr));
        checkOutput({tag, ".busy"},    int'(bus.busy), 0);
        checkOutput({tag, ".pins"},    pins(), 15);
        @(negedge clk);
        checkOutput({tag, ".errPulse"}, int'(bus.err), 0);
        checkOutput({tag, ".busy2"},    int'(bus.busy), 0);
        checkOutput({tag, ".pins2"},    pins(), 15);
    endtask

    initial begin
        int found;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start = 1'b0;
        bus.max_digits = 2'd0;
        bus.cur_digit_1 = 4'd0; bus.cur_digit_2 = 4'd0; bus.cur_digit_3 = 4'd0;
        bus.guess_digit_1 = 4'd0; bus.guess_digit_2 = 4'd0; bus.guess_digit_3 = 4'd0;
        #12;
        checkOutput("reset.digits",  int'(bus.digit_btn_n), 7);
        checkOutput("reset.confirm", int'(bus.confirm_btn_n), 1);
        checkOutput("reset.busy",    int'(bus.busy), 0);
        checkOutput("reset.done",    int'(bus.done), 0);
        checkOutput("reset.err",     int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(3, 0, 0, 0, 3, 0, 1);
        expectAccepted("mixed", -1, 1'b0);

        applyStimulus(1, 7, 3, 9, 2, 15, 0);
        expectAccepted("wrap", -1, 1'b0);

        applyStimulus(3, 4, 8, 9, 4, 8, 9);
        expectAccepted("equal", -1, 1'b1);

        applyStimulus(0, 1, 1, 1, 2, 2, 2);
        expectRejected("max0");

        applyStimulus(2, 0, 0, 0, 1, 12, 0);
        expectRejected("guess2bad");

        applyStimulus(1, 10, 0, 0, 3, 0, 0);
        expectRejected("cur1bad");

        applyStimulus(2, 1, 9, 0, 1, 2, 12);
        expectAccepted("inactive3", -1, 1'b0);

        applyStimulus(3, 2, 5, 8, 6, 1, 3);
        expectAccepted("snapshot", 40, 1'b0);

        // Abort during a digit-2 press, then confirm the block restarts cleanly.
        applyStimulus(2, 0, 0, 0, 0, 5, 0);
        found = 0;
        for (int cyc = 0; cyc < 200 && found == 0; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.digit_btn_n[1] == 1'b0) found = 1;
        end
        checkOutput("abort.reachedPress", found, 1);
        void'(sb.pop_front());
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.pins", pins(), 15);
        checkOutput("abort.busy", int'(bus.busy), 0);
        checkOutput("abort.done", int'(bus.done), 0);
        @(negedge clk);
        checkOutput("abort.heldPins", pins(), 15);
        rst_n = 1'b1;

        applyStimulus(2, 0, 8, 0, 0, 1, 0);
        expectAccepted("afterAbort", -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
